approx_pg_adder_pipe: RTL and testbench
=======================================

APPROX_PG_ADDER_PIPE -- requirements
Module: approx_pg_adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/sum width (legal range 4..64).
REQ-002 SHALL have parameter APPROX_MAX, default 8, maximum approximated low bits (legal range 0..WIDTH-1).
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 in_valid  in  1  operand beat offered.
REQ-007 in_ready  out  1  block accepts the beat this cycle.
REQ-008 a, b  in  WIDTH  operands.
REQ-009 cin  in  1  carry in.
REQ-010 approx_bits  in  $clog2(APPROX_MAX+1), min 1  requested approximated low bits k.
REQ-011 out_valid  out  1  result beat presented.
REQ-012 out_ready  in  1  consumer accepts the result.
REQ-013 sum  out  WIDTH  result.
REQ-014 cout  out  1  carry out of bit WIDTH-1.
REQ-015 p_all  out  1  exact group propagate, AND of (a XOR b) over all bits.
REQ-016 g_all  out  1  exact group generate, i.e. the carry out of a+b with cin=0.

Function
REQ-017 SHALL be a 2-stage pipeline: stage 1 operand/isolation registers plus bitwise P/G; stage 2 prefix carry, sum and result registers.
REQ-018 Latency SHALL be 2 cycles, from the accepting edge to out_valid; throughput 1 beat/cycle when out_ready=1.
REQ-019 Accept on in_valid && in_ready; stage-1 registers SHALL load only on accept and otherwise hold, so the P/G logic sees no toggling.
REQ-020 in_ready = !s1_valid || !s2_valid || out_ready; stage 1 advances into stage 2 when s1_valid && (!s2_valid || out_ready).
REQ-021 While out_valid && !out_ready, sum, cout, p_all and g_all SHALL remain stable and no beat is dropped or duplicated.
REQ-022 Effective k = min(approx_bits, APPROX_MAX), captured at accept; k=0 SHALL give an exact sum a+b+cin.
REQ-023 For k>0: sum[i] = a[i] | b[i] for i<k; the carry into bit k = a[k-1] & b[k-1]; cin is ignored; bits k..WIDTH-1 are an exact add with that carry.
REQ-024 cout SHALL be the carry out of the top bit under the same mode; p_all and g_all are always exact and independent of k.
REQ-025 Simultaneous accept and output-drain in the same cycle SHALL both take effect.
REQ-026 WIDTH wrap-around: sum is taken modulo 2^WIDTH and overflow is reported only in cout.

Reset
REQ-027 On a rst_n=0 edge: s1_valid=0, s2_valid=0, out_valid=0, sum=0, cout=0, p_all=0, g_all=0; operand registers cleared to 0.
REQ-028 in_ready SHALL be 1 in the first cycle after reset release.
REQ-029 Reset mid-operation SHALL discard in-flight beats; no out_valid is produced for them after release.

Structure
REQ-030 Shared package approx_pkg SHALL hold the mode constants (EXACT = 0) and the clamp function for k.
REQ-031 A combinational sub-module pg_vector (WIDTH-parametrised bitwise P/G generator) SHALL be instantiated in stage 1.
REQ-032 Carry computation SHALL be a parallel prefix (Kogge-Stone or Brent-Kung), not ripple.

Verification (WIDTH=8, APPROX_MAX=4)
REQ-033 Send a=0xFF, b=0x01, cin=0, k=0 -> 2 cycles later sum=0x00, cout=1, p_all=0, g_all=1.
REQ-034 Send a=0x0F, b=0x01, k=4 -> sum=0x0F, cout=0; a=0x18, b=0x08, k=4 -> sum=0x28.
REQ-035 Send approx_bits=7 -> behaviour identical to k=4; a=0x55, b=0xAA, cin=1, k=0 -> sum=0x00, cout=1, p_all=1.
REQ-036 Hold out_ready=0 with continuous in_valid -> exactly two beats accepted, then in_ready=0; outputs stable; releasing out_ready delivers the beats in order with no loss.
REQ-037 Assert rst_n=0 with two beats in flight -> outputs zero next cycle, no stale out_valid after release.
REQ-038 Random back-to-back traffic with random out_ready -> every result matches a reference model of REQ-022..024.

Source files
------------

// File: rtl/approx_pkg.sv
// -----------------------------------------------------------------------------
// approx_pkg
// Shared definitions for the approximate parallel-prefix adder.
//   mode_e   : adder mode. EXACT (0) is a full carry-propagating add;
//              APPROX treats the low k bits as carry-free OR bits.
//   clamp_k  : limits a requested approximation width to the build-time
//              maximum.
// -----------------------------------------------------------------------------
package approx_pkg;

  typedef enum logic {
    EXACT  = 1'b0,
    APPROX = 1'b1
  } mode_e;

  function automatic int unsigned clamp_k(input int unsigned req,
                                          input int unsigned kmax);
    return (req > kmax) ? kmax : req;
  endfunction

endpackage

// File: rtl/pg_vector.sv
// -----------------------------------------------------------------------------
// pg_vector
// Bitwise propagate/generate generator, purely combinational.
// Ports:
//   a, b : operands (WIDTH bits)
//   p    : per-bit propagate, a ^ b
//   g    : per-bit generate,  a & b
// -----------------------------------------------------------------------------
module pg_vector
  import approx_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] g
);

  assign p = a ^ b;
  assign g = a & b;

endmodule

// File: rtl/approx_pg_adder_pipe.sv
// -----------------------------------------------------------------------------
// approx_pg_adder_pipe
// Two-stage pipelined adder with a configurable number of approximated low
// bits. Stage 1 captures the operands (only on accept, so the P/G logic behind
// it stays quiet while idle) and forms bitwise P/G. Stage 2 runs a Kogge-Stone
// prefix carry network, forms the sum and registers the result.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid / in_ready   : operand handshake
//   a, b, cin             : operands and carry-in
//   approx_bits           : requested approximated low bits k (clamped to
//                           APPROX_MAX at accept)
//   out_valid / out_ready : result handshake
//   sum, cout             : result and carry out of the top bit
//   p_all, g_all          : exact group propagate / generate of a, b
// -----------------------------------------------------------------------------
module approx_pg_adder_pipe
  import approx_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int APPROX_MAX = 8,
  localparam int KW         = (APPROX_MAX > 0) ? $clog2(APPROX_MAX + 1) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [KW-1:0]    approx_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             p_all,
  output logic             g_all
);

  // Kogge-Stone prefix over (g, p). Returns the group generate of bits [i:0]
  // for every i, i.e. the carry out of each bit position. Propagate shifts in
  // ones so positions already complete keep their group propagate.
  function automatic logic [WIDTH-1:0] ks_prefix(input logic [WIDTH-1:0] g_in,
                                                 input logic [WIDTH-1:0] p_in);
    logic [WIDTH-1:0] gv;
    logic [WIDTH-1:0] pv;
    gv = g_in;
    pv = p_in;
    for (int s = 1; s < WIDTH; s = s * 2) begin
      gv = gv | (pv & (gv << s));
      pv = pv & ~((~pv) << s);
    end
    return gv;
  endfunction

  logic             vld_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic             cin_p1;
  logic [KW-1:0]    k_p1;
  logic [WIDTH-1:0] p_p1;
  logic [WIDTH-1:0] g_p1;

  logic             vld_p2;

  logic             accept;
  logic             advance;
  logic [KW-1:0]    k_in;

  assign in_ready  = !vld_p1 || !vld_p2 || out_ready;
  assign accept    = in_valid && in_ready;
  assign advance   = vld_p1 && (!vld_p2 || out_ready);
  assign out_valid = vld_p2;
  assign k_in      = KW'(clamp_k(32'(approx_bits), 32'(APPROX_MAX)));

  // ---- stage 1: operand capture ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      a_p1   <= '0;
      b_p1   <= '0;
      cin_p1 <= 1'b0;
      k_p1   <= '0;
    end else begin
      if (accept) begin
        vld_p1 <= 1'b1;
        a_p1   <= a;
        b_p1   <= b;
        cin_p1 <= cin;
        k_p1   <= k_in;
      end else if (advance) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  pg_vector #(
    .WIDTH (WIDTH)
  ) u_pg (
    .a (a_p1),
    .b (b_p1),
    .p (p_p1),
    .g (g_p1)
  );

  // ---- stage 2: prefix carry and sum ----
  mode_e            mode;
  logic [WIDTH-1:0] lo_mask;
  logic             cin_sel;
  logic [WIDTH-1:0] pm;
  logic [WIDTH-1:0] gm;
  logic [WIDTH-1:0] gf;
  logic [WIDTH-1:0] gc;
  logic [WIDTH-1:0] carry_in;
  logic [WIDTH-1:0] ge;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             p_all_c;
  logic             g_all_c;

  always_comb begin
    mode    = (k_p1 == '0) ? EXACT : APPROX;
    lo_mask = ~({WIDTH{1'b1}} << k_p1);
    cin_sel = (mode == EXACT) ? cin_p1 : 1'b0;
    // Approximated bits are cut out of the carry chain, except that the
    // generate of bit k-1 is kept so it becomes the carry into bit k.
    pm      = p_p1 & ~lo_mask;
    gm      = g_p1 & ~(lo_mask >> 1);
    // Carry-in folded into bit 0's generate so the prefix needs no extra slot.
    gf      = gm | {{(WIDTH-1){1'b0}}, pm[0] & cin_sel};
    gc      = ks_prefix(gf, pm);
    carry_in = {gc[WIDTH-2:0], cin_sel};
    sum_c   = ((p_p1 ^ carry_in) & ~lo_mask) | ((p_p1 | g_p1) & lo_mask);
    cout_c  = gc[WIDTH-1];
    // Exact group generate: carry out of the full-width a+b with no cin.
    ge      = ks_prefix(g_p1, p_p1);
    g_all_c = (ge >> (WIDTH-1)) != '0;
    p_all_c = &p_p1;
  end

  // ---- stage 2 result registers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      p_all  <= 1'b0;
      g_all  <= 1'b0;
    end else begin
      if (advance) begin
        vld_p2 <= 1'b1;
        sum    <= sum_c;
        cout   <= cout_c;
        p_all  <= p_all_c;
        g_all  <= g_all_c;
      end else if (out_ready) begin
        vld_p2 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_approx_pg_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_approx_pg_adder_pipe
// Directed table of hand-computed vectors plus sequences for backpressure,
// simultaneous accept/drain, mid-flight reset and mixed random traffic.
// Expected result record layout: {cout, sum[7:0], p_all, g_all}.
// -----------------------------------------------------------------------------
module tb_approx_pg_adder_pipe;

  localparam int W  = 8;
  localparam int AM = 4;
  localparam int KW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;
  logic [KW-1:0] approx_bits = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  sum;
  logic          cout;
  logic          p_all;
  logic          g_all;

  int tests   = 0;
  int fails   = 0;
  int acc_cnt = 0;
  int stale   = 0;
  logic [10:0] sb[$];

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic        vc;
    logic [2:0]  vk;
    logic [10:0] exp;
  } vec_t;

  vec_t tab[12];

  approx_pg_adder_pipe #(
    .WIDTH      (W),
    .APPROX_MAX (AM)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .approx_bits (approx_bits),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (sum),
    .cout        (cout),
    .p_all       (p_all),
    .g_all       (g_all)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  // Behavioural reference: plain integer adds on split fields.
  function automatic logic [10:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                        input logic mc, input logic [2:0] mk);
    int         k;
    logic [8:0] full;
    logic [8:0] hi;
    logic [8:0] ex;
    logic [7:0] lo_m;
    k = (mk > 3'd4) ? 4 : int'(mk);
    if (k == 0) begin
      full = {1'b0, ma} + {1'b0, mb} + 9'(mc);
    end else begin
      lo_m = 8'((1 << k) - 1);
      hi   = {1'b0, ma >> k} + {1'b0, mb >> k} + 9'(ma[k-1] & mb[k-1]);
      full = (hi << k) | {1'b0, (ma | mb) & lo_m};
    end
    ex = {1'b0, ma} + {1'b0, mb};
    return {full[8], full[7:0], &(ma ^ mb), ex[8]};
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  // One clock of traffic: drive at the falling edge, then settle and record
  // which handshakes will complete on the next rising edge.
  task automatic cycle(input logic iv, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic tc, input logic [2:0] tk, input logic ordy,
                       input logic [10:0] texp);
    logic [10:0] e;
    @(negedge clk);
    in_valid    = iv;
    a           = ta;
    b           = tb_;
    cin         = tc;
    approx_bits = tk;
    out_ready   = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        stale++;
        $display("FAIL unexpected_beat: got out_valid with sum 0x%0h, expected no beat", sum);
      end else begin
        e = sb.pop_front();
        check("beat", 64'({cout, sum, p_all, g_all}), 64'(e));
      end
    end
    if (in_valid && in_ready) begin
      sb.push_back(texp);
      acc_cnt++;
    end
  endtask

  logic [10:0] snap;
  logic [10:0] cur;
  logic        have;
  logic        stable;
  logic [7:0]  ra;
  logic [7:0]  rb;
  logic        rc;
  logic [2:0]  rk;
  logic        riv;
  logic        rrdy;

  initial begin
    //            a      b      cin   k      {cout, sum,  p, g}
    tab[0]  = '{8'hFF, 8'h01, 1'b0, 3'd0, {1'b1, 8'h00, 1'b0, 1'b1}};
    tab[1]  = '{8'h0F, 8'h01, 1'b0, 3'd4, {1'b0, 8'h0F, 1'b0, 1'b0}};
    tab[2]  = '{8'h18, 8'h08, 1'b0, 3'd4, {1'b0, 8'h28, 1'b0, 1'b0}};
    tab[3]  = '{8'h0F, 8'h01, 1'b0, 3'd7, {1'b0, 8'h0F, 1'b0, 1'b0}};
    tab[4]  = '{8'h18, 8'h08, 1'b1, 3'd7, {1'b0, 8'h28, 1'b0, 1'b0}};
    tab[5]  = '{8'h55, 8'hAA, 1'b1, 3'd0, {1'b1, 8'h00, 1'b1, 1'b0}};
    tab[6]  = '{8'hF0, 8'h10, 1'b1, 3'd2, {1'b1, 8'h00, 1'b0, 1'b1}};
    tab[7]  = '{8'h03, 8'h03, 1'b1, 3'd1, {1'b0, 8'h07, 1'b0, 1'b0}};
    tab[8]  = '{8'h80, 8'h80, 1'b0, 3'd3, {1'b1, 8'h00, 1'b0, 1'b1}};
    tab[9]  = '{8'hFF, 8'h00, 1'b1, 3'd0, {1'b1, 8'h00, 1'b1, 1'b0}};
    tab[10] = '{8'h7F, 8'h01, 1'b0, 3'd0, {1'b0, 8'h80, 1'b0, 1'b0}};
    tab[11] = '{8'hA5, 8'h5A, 1'b0, 3'd4, {1'b0, 8'hFF, 1'b1, 1'b0}};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum",       64'(sum),       64'(0));
    check("rst_cout",      64'(cout),      64'(0));
    check("rst_p_all",     64'(p_all),     64'(0));
    check("rst_g_all",     64'(g_all),     64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("in_ready_after_reset", 64'(in_ready), 64'(1));

    // Directed table, one beat at a time
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, tab[i].va, tab[i].vb, tab[i].vc, tab[i].vk, 1'b1, tab[i].exp);
      cycle(1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1, 11'd0);
      if (i == 0) check("latency_not_early", 64'(out_valid), 64'(0));
      cycle(1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1, 11'd0);
      if (i == 0) check("latency_two", 64'(out_valid), 64'(1));
    end
    check("table_drained", 64'(sb.size()), 64'(0));

    // Backpressure: consumer stalled, producer keeps offering
    acc_cnt = 0;
    have    = 1'b0;
    stable  = 1'b1;
    snap    = '0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 8'(8'h10 + i), 8'h01, 1'b0, 3'd0, 1'b0, model(8'(8'h10 + i), 8'h01, 1'b0, 3'd0));
      cur = {cout, sum, p_all, g_all};
      if (out_valid) begin
        if (!have) begin
          snap = cur;
          have = 1'b1;
        end else if (cur !== snap) begin
          stable = 1'b0;
        end
      end
    end
    check("bp_accepted",     64'(acc_cnt),  64'(2));
    check("bp_in_ready_low", 64'(in_ready), 64'(0));
    check("bp_out_valid",    64'(have),     64'(1));
    check("bp_stable",       64'(stable),   64'(1));
    // Release while still feeding: accept and drain in the same cycles
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 8'(8'h40 + i), 8'h02, 1'b1, 3'd0, 1'b1, model(8'(8'h40 + i), 8'h02, 1'b1, 3'd0));
    repeat (4) cycle(1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1, 11'd0);
    check("bp_drained", 64'(sb.size()), 64'(0));

    // Mixed traffic with random stalls
    for (int i = 0; i < 400; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rc   = 1'($urandom_range(0, 1));
      rk   = 3'($urandom_range(0, 7));
      riv  = ($urandom_range(0, 3) != 0);
      rrdy = ($urandom_range(0, 3) != 0);
      cycle(riv, ra, rb, rc, rk, rrdy, model(ra, rb, rc, rk));
    end
    repeat (6) cycle(1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1, 11'd0);
    check("random_drained", 64'(sb.size()), 64'(0));

    // Reset with two beats in flight
    cycle(1'b1, 8'h33, 8'h44, 1'b0, 3'd0, 1'b1, model(8'h33, 8'h44, 1'b0, 3'd0));
    cycle(1'b1, 8'h12, 8'h34, 1'b0, 3'd0, 1'b1, model(8'h12, 8'h34, 1'b0, 3'd0));
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_sum",       64'(sum),       64'(0));
    check("midrst_cout",      64'(cout),      64'(0));
    check("midrst_p_all",     64'(p_all),     64'(0));
    check("midrst_g_all",     64'(g_all),     64'(0));
    sb.delete();
    rst_n = 1'b1;
    stale = 0;
    repeat (6) cycle(1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1, 11'd0);
    check("midrst_no_stale", 64'(stale), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
